// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sequencer.
//   state_t : sequencer FSM states
//   IDX_W   : vector index width ({x,y})
//   N_VEC   : number of input vectors in the table
//   CNT_W   : settle counter width
//   ERR_W   : mismatch counter width (holds 0..N_VEC)
package tt_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int IDX_W = 2;
  localparam int N_VEC = 4;
  localparam int CNT_W = 4;
  localparam int ERR_W = 3;
endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// settle_timer: counts cycles an input vector has been held.
//   clk     : clock
//   rst     : synchronous reset, active-high
//   clear   : zero the count
//   en      : advance the count; wraps to 0 after reaching SETTLE-1
//   expired : count == SETTLE-1 (last settle cycle of the vector)
// SETTLE legal range 1..15.
module settle_timer
  import tt_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en)      cnt <= expired ? '0 : cnt + CNT_W'(1);
  end
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks a 2-input unit s = f(x,y) through its truth
// table, captures s per vector and compares against EXPECT.
//   clk     : clock
//   rst     : synchronous reset, active-high (abandons any run)
//   start   : request a run; only looked at in IDLE
//   s_i     : unit output
//   x_o,y_o : unit stimulus; 0 outside DRIVE/SAMPLE
//   busy    : high in DRIVE and SAMPLE
//   done    : one-cycle pulse when a run completes
//   pass    : result of last completed run (err_cnt == 0)
//   table_o : captured s, bit index {x,y}
//   err_cnt : entries differing from EXPECT
module truth_table_sequencer
  import tt_pkg::*;
#(
  parameter int                 SETTLE = 2,
  parameter logic [N_VEC-1:0]   EXPECT = 4'b0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_i,
  output logic             x_o,
  output logic             y_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_VEC-1:0] table_o,
  output logic [ERR_W-1:0] err_cnt
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [N_VEC-1:0] tbl;
  logic [ERR_W-1:0] err;
  logic             pass_q;
  logic             expired;

  // Counter is held at zero whenever we are not driving, so every DRIVE
  // phase starts a fresh settle interval.
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != DRIVE),
    .en     (state == DRIVE),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (expired) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == LAST_IDX) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      tbl    <= '0;
      err    <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx <= '0;
          tbl <= '0;
          err <= '0;
        end
        SAMPLE: begin
          tbl[idx] <= s_i;
          if (s_i != EXPECT[idx]) err <= err + ERR_W'(1);
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        // err already includes the final sample here.
        DONE:    pass_q <= (err == '0);
        default: ;
      endcase
    end
  end

  assign busy    = (state == DRIVE) || (state == SAMPLE);
  assign done    = (state == DONE);
  assign x_o     = busy & idx[1];
  assign y_o     = busy & idx[0];
  assign pass    = pass_q;
  assign table_o = tbl;
  assign err_cnt = err;
endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Sequential controller that runs a 2-input combinational unit under test, of the form s = f(x, y), through its full truth table.
- Drives x/y, waits a settle interval, samples s, captures the 4-entry table, and compares it with an expected table.
- Reports pass/fail and the mismatch count through a start/done handshake.
- Replaces the hand-written #1 stimulus benches with a synthesizable self-check that sits beside the unit.

Parameters:
- SETTLE, 2, cycles each input vector is held before s is sampled; legal range 1..15.
- EXPECT, 4'b0010, expected truth table; bit index = {x,y}. Default encodes s = ~x & y.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a run; sampled only in IDLE.
- s_i  input  1  output of the unit under test.
- x_o  output  1  x stimulus to the unit under test.
- y_o  output  1  y stimulus to the unit under test.
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  one-cycle pulse, high in DONE.
- pass  output  1  result of the last completed run; held until the next run completes.
- table_o  output  4  captured s values, bit {x,y}.
- err_cnt  output  3  number of table entries differing from EXPECT (0..4).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; idx=0; settle counter=0; x_o=y_o=0; busy=done=pass=0; table_o=0; err_cnt=0.
- Reset has priority over every other event, including mid-run. A run interrupted by reset is abandoned and produces no done.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - x_o=y_o=0.
  - start=1 -> DRIVE; clear idx, settle counter, table_o and err_cnt; pass is unchanged.
- DRIVE:
  - x_o=idx[1], y_o=idx[0].
  - Settle counter increments each cycle; when it equals SETTLE-1, go to SAMPLE and clear the counter.
  - Vector order is 00, 01, 10, 11 ({x,y}).
- SAMPLE (one cycle):
  - x_o/y_o hold the current vector.
  - table_o[idx] <= s_i.
  - If s_i != EXPECT[idx], err_cnt <= err_cnt+1.
  - If idx==3 -> DONE; otherwise idx <= idx+1 (2-bit, no wrap used) and return to DRIVE.
- DONE (one cycle):
  - done=1; pass <= (err_cnt==0), where err_cnt already includes the last sample; go to IDLE.
  - x_o=y_o=0.
- busy is a registered/decoded state flag: 1 in DRIVE and SAMPLE only.
- Timing, with start sampled at edge 0:
  - DRIVE for vector k occupies cycles k*(SETTLE+1)+1 .. k*(SETTLE+1)+SETTLE.
  - SAMPLE for vector k occurs at cycle (k+1)*(SETTLE+1).
  - done is high in cycle 4*(SETTLE+1)+1.
  - For SETTLE=2, done is high in cycle 13.
- start is ignored while busy or in DONE; it is never queued.
- If start is still high in the IDLE cycle after DONE, a new run begins, so held-high start gives back-to-back runs with one IDLE cycle between.
- Arithmetic: err_cnt is 3 bits and saturation is unnecessary (maximum value 4). The settle counter is 4 bits.
- s_i is sampled only in SAMPLE; glitches during DRIVE have no effect.

Decomposition:
- Shared package tt_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - constants IDX_W=2, N_VEC=4, CNT_W=4, ERR_W=3.
- One sub-module, settle_timer:
  - inputs clk, rst, clear, en;
  - output expired, high when count==SETTLE-1;
  - parameter SETTLE.
- The top level holds the FSM, idx, table/err registers and the output decode.

Test Plan:
- Unit s=~x&y, SETTLE=2, start pulsed at cycle 0 -> x_o/y_o step 00,01,10,11; table_o=4'b0010; err_cnt=0; pass=1; done high only in cycle 13.
- Unit stuck at s=0 -> table_o=4'b0000; err_cnt=1; pass=0; done timing unchanged.
- Unit s=~(~x&y) -> table_o=4'b1101; err_cnt=4; pass=0.
- start pulsed again in cycles 3 and 8 of a run -> no restart; done appears exactly once, in cycle 13.
- rst=1 at cycle 6 of a run, with start reasserted at cycle 8 -> at cycle 7 all outputs are 0 and state is IDLE. The new run completes with done in cycle 21 and correct table; no done from the aborted run.
- start held high continuously, SETTLE=1 -> done pulses in cycles 9, 19 and 29. Each run has 8 busy cycles, then DONE, then one IDLE cycle. pass is stable between pulses.
